// File: rtl/ic_init_loader.sv
// Byte-stream I-cache image loader: assembles little-endian words from the UART
// receiver, writes them through I-cache port A, and streams the image back on request.
module ic_init_loader #(
    parameter int DATA = 32,
    parameter int ADDR = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              dump_req,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              IC_Init,
    output logic [ADDR-1:0]   IC_Init_Addr,
    output logic [DATA-1:0]   IC_Init_Data,
    output logic              Init_Done,
    output logic [ADDR-1:0]   IC_WriteBack_Addr,
    input  logic [DATA-1:0]   IC_WriteBack_Data,
    output logic              Load_Err
);

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        LOAD    = 3'd2,
        DONE    = 3'd3,
        RD_ADDR = 3'd4,
        RD_WAIT = 3'd5,
        SEND    = 3'd6
    } state_t;

    localparam logic [31:0]   CAP32 = 32'd1 << ADDR;
    localparam logic [ADDR:0] CAP   = {1'b1, {ADDR{1'b0}}};

    state_t          state_r;
    logic [7:0]      hdr_lo_r;
    logic [ADDR:0]   count_r;
    logic [ADDR:0]   widx_r;
    logic [1:0]      bidx_r;
    logic [DATA-9:0] word_r;
    logic [DATA-1:0] shift_r;

    logic [31:0]     hdr_n_s;
    logic [ADDR:0]   widx_nxt_s;

    assign hdr_n_s    = {16'h0000, rx_data, hdr_lo_r};
    assign widx_nxt_s = widx_r + (ADDR+1)'(1);

    // Loader / readback state machine; the word counter is shared by load and dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= HDR_LO;
            hdr_lo_r          <= 8'h00;
            count_r           <= '0;
            widx_r            <= '0;
            bidx_r            <= 2'd0;
            word_r            <= '0;
            shift_r           <= '0;
            tx_valid          <= 1'b0;
            tx_data           <= 8'h00;
            IC_Init           <= 1'b0;
            IC_Init_Addr      <= '0;
            IC_Init_Data      <= '0;
            Init_Done         <= 1'b0;
            IC_WriteBack_Addr <= '0;
            Load_Err          <= 1'b0;
        end else begin
            IC_Init <= 1'b0;
            case (state_r)
                HDR_LO: begin
                    if (rx_valid) begin
                        hdr_lo_r <= rx_data;
                        state_r  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (rx_valid) begin
                        widx_r <= '0;
                        bidx_r <= 2'd0;
                        if (hdr_n_s == 32'd0) begin
                            count_r   <= '0;
                            Init_Done <= 1'b1;
                            state_r   <= DONE;
                        end else if (hdr_n_s > CAP32) begin
                            // Oversize image: load what fits, the surplus arrives in DONE
                            Load_Err <= 1'b1;
                            count_r  <= CAP;
                            state_r  <= LOAD;
                        end else begin
                            count_r <= hdr_n_s[ADDR:0];
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        word_r <= {rx_data, word_r[DATA-9:8]};
                        bidx_r <= bidx_r + 2'd1;
                        if (bidx_r == 2'd3) begin
                            IC_Init      <= 1'b1;
                            IC_Init_Data <= {rx_data, word_r};
                            IC_Init_Addr <= widx_r[ADDR-1:0];
                            widx_r       <= widx_nxt_s;
                            if (widx_nxt_s == count_r) begin
                                state_r <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    Init_Done <= 1'b1;
                    if (dump_req && (count_r != '0)) begin
                        widx_r            <= '0;
                        IC_WriteBack_Addr <= '0;
                        state_r           <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    // BRAM output register now holds the addressed word
                    tx_data  <= IC_WriteBack_Data[7:0];
                    shift_r  <= {8'h00, IC_WriteBack_Data[DATA-1:8]};
                    tx_valid <= 1'b1;
                    bidx_r   <= 2'd0;
                    state_r  <= SEND;
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (bidx_r == 2'd3) begin
                            tx_valid <= 1'b0;
                            if (widx_nxt_s == count_r) begin
                                state_r <= DONE;
                            end else begin
                                widx_r            <= widx_nxt_s;
                                IC_WriteBack_Addr <= widx_nxt_s[ADDR-1:0];
                                state_r           <= RD_ADDR;
                            end
                        end else begin
                            bidx_r  <= bidx_r + 2'd1;
                            tx_data <= shift_r[7:0];
                            shift_r <= {8'h00, shift_r[DATA-1:8]};
                        end
                    end
                end
                default: begin
                    state_r <= HDR_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic_init_loader.sv
// Directed bench for ic_init_loader with a registered-output BRAM model on the
// writeback port.
module tb_ic_init_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        dump_req;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        IC_Init;
    logic [9:0]  IC_Init_Addr;
    logic [31:0] IC_Init_Data;
    logic        Init_Done;
    logic [9:0]  IC_WriteBack_Addr;
    logic [31:0] IC_WriteBack_Data;
    logic        Load_Err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    logic [31:0] mem [1024];

    ic_init_loader #(.DATA(32), .ADDR(10)) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .dump_req          (dump_req),
        .tx_ready          (tx_ready),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .IC_Init           (IC_Init),
        .IC_Init_Addr      (IC_Init_Addr),
        .IC_Init_Data      (IC_Init_Data),
        .Init_Done         (Init_Done),
        .IC_WriteBack_Addr (IC_WriteBack_Addr),
        .IC_WriteBack_Data (IC_WriteBack_Data),
        .Load_Err          (Load_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I-cache port A model: write on IC_Init, registered read data.
    always @(posedge clk) begin
        if (IC_Init) begin
            mem[IC_Init_Addr] <= IC_Init_Data;
            wr_cnt <= wr_cnt + 1;
        end
        IC_WriteBack_Data <= mem[IC_WriteBack_Addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
    endtask

    task automatic send_word(input logic [9:0] addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
        chk("ic_init_pulse", {31'd0, IC_Init}, 32'd1);
        chk("ic_init_addr", {22'd0, IC_Init_Addr}, {22'd0, addr});
        chk("ic_init_data", IC_Init_Data, w);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b [12];
        logic [7:0] pat [4];
        logic       prev_stall;
        logic [7:0] prev_data;
        int         got;
        int         base;

        exp_b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'h78, 8'h56, 8'h34, 8'h12};
        pat   = '{8'h01, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        IC_WriteBack_Data = 32'h0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; dump_req = 1'b0; tx_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_ic_init", {31'd0, IC_Init}, 32'd0);
        chk("rst_init_done", {31'd0, Init_Done}, 32'd0);
        chk("rst_load_err", {31'd0, Load_Err}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_init_addr", {22'd0, IC_Init_Addr}, 32'd0);
        chk("rst_init_data", IC_Init_Data, 32'd0);
        chk("rst_wb_addr", {22'd0, IC_WriteBack_Addr}, 32'd0);

        // Three-word load, back-to-back bytes
        send_byte(8'h03);
        send_byte(8'h00);
        send_word(10'd0, 32'h00000013);
        chk("done_mid_load", {31'd0, Init_Done}, 32'd0);
        send_word(10'd1, 32'hDEADBEEF);
        send_word(10'd2, 32'h12345678);
        chk("done_at_last_pulse", {31'd0, Init_Done}, 32'd0);
        rx_valid = 1'b0;
        step();
        chk("done_after_load", {31'd0, Init_Done}, 32'd1);
        chk("init_pulse_drops", {31'd0, IC_Init}, 32'd0);
        chk("load_err_3w", {31'd0, Load_Err}, 32'd0);
        chk("wr_cnt_3w", wr_cnt, 32'd3);

        // Bytes received in DONE are ignored
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        rx_valid = 1'b0;
        step();
        step();
        chk("wr_cnt_after_extra", wr_cnt, 32'd3);
        chk("done_after_extra", {31'd0, Init_Done}, 32'd1);

        // Dump with tx_ready toggling 1,0,0,1
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        chk("dump_lat_1", {31'd0, tx_valid}, 32'd0);
        step();
        chk("dump_lat_2", {31'd0, tx_valid}, 32'd0);
        step();
        chk("dump_lat_3", {31'd0, tx_valid}, 32'd1);
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        got = 0;
        for (int c = 0; c < 120; c++) begin
            tx_ready = pat[c % 4][0];
            dump_req = (c == 10);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (got < 12) chk("dump_byte", {24'd0, tx_data}, {24'd0, exp_b[got]});
                got++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            step();
        end
        dump_req = 1'b0;
        tx_ready = 1'b0;
        chk("dump_count", got, 32'd12);
        chk("dump_idle", {31'd0, tx_valid}, 32'd0);

        // Back in DONE: a second dump starts again at word 0
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        step();
        step();
        chk("redump_valid", {31'd0, tx_valid}, 32'd1);
        chk("redump_byte0", {24'd0, tx_data}, 32'h13);
        tx_ready = 1'b1;
        for (int c = 0; c < 40; c++) step();
        tx_ready = 1'b0;
        chk("redump_idle", {31'd0, tx_valid}, 32'd0);

        // Reset in the middle of word 1
        do_reset();
        base = wr_cnt;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(10'd0, 32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        do_reset();
        step();
        chk("midrst_done", {31'd0, Init_Done}, 32'd0);
        chk("midrst_writes", wr_cnt - base, 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(10'd0, 32'hCAFEF00D);
        chk("midrst_done_pulse", {31'd0, Init_Done}, 32'd0);
        rx_valid = 1'b0;
        step();
        chk("midrst_done_after", {31'd0, Init_Done}, 32'd1);
        chk("midrst_total", wr_cnt - base, 32'd2);

        // Empty image
        do_reset();
        base = wr_cnt;
        send_byte(8'h00);
        chk("empty_done_early", {31'd0, Init_Done}, 32'd0);
        send_byte(8'h00);
        rx_valid = 1'b0;
        chk("empty_done", {31'd0, Init_Done}, 32'd1);
        chk("empty_no_pulse", {31'd0, IC_Init}, 32'd0);
        step();
        chk("empty_writes", wr_cnt - base, 32'd0);

        // Oversize header 01 05 = 1281 words, clamped to 1024
        do_reset();
        base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h05);
        chk("oversize_err", {31'd0, Load_Err}, 32'd1);
        for (int i = 0; i < 1024; i++) begin
            send_word(10'(i), 32'hA5000000 ^ 32'(i * 7));
        end
        chk("oversize_done_pulse", {31'd0, Init_Done}, 32'd0);
        send_byte(8'h11);
        chk("oversize_done", {31'd0, Init_Done}, 32'd1);
        for (int i = 0; i < 7; i++) send_byte(8'h22);
        rx_valid = 1'b0;
        step();
        step();
        chk("oversize_writes", wr_cnt - base, 32'd1024);
        chk("oversize_last_word", mem[1023], 32'hA5000000 ^ 32'(1023 * 7));
        chk("oversize_err_sticky", {31'd0, Load_Err}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ic_init_loader.md
# ic_init_loader

Byte-stream loader that fills the instruction cache through its init/debug port. It sits in the UART clock domain between the UART receiver/transmitter and the I-cache port A. It assembles received bytes into 32-bit instruction words and writes them to sequential I-cache addresses, then raises `Init_Done` to release the fetch stage. On request it reads the loaded image back over the writeback port and streams it out as bytes for host-side verification.

## Interface
Parameters:
- `DATA`, 32, instruction word width; fixed at 32, four bytes per word.
- `ADDR`, 10, I-cache word-address width; capacity is 2^ADDR words.

Ports:
- `clk`  in  1  UART-domain clock, the same clock that drives I-cache port A.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `dump_req`  in  1  one-cycle pulse requesting readback; honoured only in DONE.
- `tx_ready`  in  1  transmitter can accept a byte.
- `tx_valid`  out  1  `tx_data` holds a byte to send.
- `tx_data`  out  8  byte to transmit.
- `IC_Init`  out  1  I-cache write enable, one-cycle pulse per word.
- `IC_Init_Addr`  out  ADDR  I-cache write word address.
- `IC_Init_Data`  out  DATA  I-cache write data.
- `Init_Done`  out  1  image fully loaded; sticky until `rst`.
- `IC_WriteBack_Addr`  out  ADDR  readback word address.
- `IC_WriteBack_Data`  in  DATA  readback data, registered BRAM output.
- `Load_Err`  out  1  header word count exceeded capacity; sticky until `rst`.

## Operation
- **Stream format:**
  - 2-byte header giving word count N, little-endian (`N = {b1,b0}`).
  - Then N words, 4 bytes each, little-endian (first byte goes to `[7:0]`).
- **States:** HDR_LO, HDR_HI, LOAD, DONE, RD_ADDR, RD_WAIT, SEND.
- **HDR_LO / HDR_HI:**
  - Capture the count bytes. On the second byte, go to DONE if N==0; otherwise go to LOAD.
  - If N > 2^ADDR: set `Load_Err` and clamp N to 2^ADDR. The excess bytes are then received in DONE and ignored.
- **LOAD:**
  - A 2-bit byte index shifts bytes into a word register.
  - On the 4th byte: drive `IC_Init_Data` = assembled word and `IC_Init_Addr` = word index, and pulse `IC_Init`.
  - After the pulse, the word index increments.
  - After word N-1 is written, go to DONE.
- **DONE:**
  - `Init_Done`=1.
  - `rx_valid` is ignored.
  - `dump_req` starts readback at word 0.
- **Readback, per word i < N:**
  - RD_ADDR: drive `IC_WriteBack_Addr`=i.
  - RD_WAIT: one cycle.
  - Then latch `IC_WriteBack_Data` into a shift register and enter SEND.
  - SEND: emit 4 bytes, LSB first, using the valid/ready handshake.
  - After the 4th byte of word N-1, return to DONE. Otherwise go to RD_ADDR with i+1.
- **Handshake rules:**
  - A byte transfers on a cycle with `tx_valid && tx_ready`.
  - While `tx_valid && !tx_ready`, `tx_data` and `tx_valid` hold.
- **Ignored inputs:**
  - `dump_req` outside DONE is ignored.
  - `rx_valid` outside HDR_LO, HDR_HI and LOAD is ignored.
- **Counter widths:**
  - The word counter is ADDR+1 bits wide, so N = 2^ADDR is representable.
  - `IC_Init_Addr` / `IC_WriteBack_Addr` are the counter's low ADDR bits.
- **Reset:**
  - `rst` at any point, including mid-word or mid-dump, returns to HDR_LO.
  - Partial words are discarded and never written.

## Timing
- **Reset values:**
  - `IC_Init`, `Init_Done`, `Load_Err` and `tx_valid` are 0.
  - `tx_data`, `IC_Init_Addr`, `IC_Init_Data` and `IC_WriteBack_Addr` are all zero.
- **Write timing:**
  - `IC_Init` is registered. It is high exactly the cycle after the clock edge that samples the 4th byte of a word.
  - `IC_Init_Addr` and `IC_Init_Data` are valid in that same cycle.
- **Init_Done timing:**
  - Rises the cycle after the last `IC_Init` pulse.
  - If N==0, it rises the cycle after the HDR_HI byte.
- **Consecutive words:** back-to-back `rx_valid` every cycle is supported. Consecutive writes are therefore 4 cycles apart.
- **Readback timing:**
  - `IC_WriteBack_Data` is sampled 2 cycles after `IC_WriteBack_Addr` updates, which covers the BRAM registered output.
  - `tx_valid` first asserts 3 cycles after the `dump_req` cycle.
- **`dump_req` during readback:** ignored. No restart occurs.

## Test plan
- **Three-word load:**
  - Stimulus: header 03 00, then words 0x00000013, 0xDEADBEEF, 0x12345678 as bytes.
  - Required: `IC_Init` pulses at addr 0, 1, 2 with those values; `Init_Done` rises the next cycle; `Load_Err`=0.
- **Empty image:** header 00 00 -> no `IC_Init`; `Init_Done`=1 one cycle after the second byte.
- **Oversize header:** 01 05 (N=1281) with ADDR=10 -> `Load_Err`=1; exactly 1024 writes at addr 0..1023; trailing bytes produce no writes.
- **Dump with backpressure:**
  - Stimulus: after the three-word load, send `dump_req` with `tx_ready` toggling 1,0,0,1.
  - Required: bytes 13 00 00 00 EF BE AD DE 78 56 34 12 in order; `tx_data` stable while stalled; returns to DONE.
- **Reset mid-word:** `rst` after 2 bytes of word 1 -> no write for word 1; a fresh header is accepted afterwards; `Init_Done`=0 until the new load completes.
- **Bytes after load:** `rx_valid` bytes in DONE -> no `IC_Init` pulse; state stays DONE.
